// File: rtl/pc_seq.sv
// Program-counter sequencer: increment with wrap point, absolute jump, relative branch,
// and an optional call/return stack enabled by defining PC_STACK_EN.
module pc_seq #(
    parameter int AW        = 7,
    parameter int PC_MAX    = 127,
    parameter int STK_DEPTH = 4
) (
    input  logic                           Clk,
    input  logic                           PC_clr,
    input  logic                           PC_up,
    input  logic                           PC_ld,
    input  logic                           PC_rel,
    input  logic                           PC_call,
    input  logic                           PC_ret,
    input  logic [AW-1:0]                  PC_addr,
    input  logic [AW-1:0]                  PC_off,
    output logic [AW-1:0]                  PCout,
    output logic [$clog2(STK_DEPTH+1)-1:0] stk_cnt,
    output logic                           stk_full,
    output logic                           stk_empty,
    output logic                           stk_err
);

    localparam int CW = $clog2(STK_DEPTH + 1);
    localparam logic [AW-1:0] MAX_A = AW'(PC_MAX);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] seq_pc;

    // Sequential successor; also the return address pushed by a call.
    assign seq_pc = (pc_q >= MAX_A) ? '0 : pc_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (PC_clr) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCout = pc_q;

`ifdef PC_STACK_EN
    localparam int IW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [AW-1:0] stk_mem [STK_DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push_en;
    logic          full, empty;
    logic [IW-1:0] push_idx, top_idx;

    assign full     = (cnt_q == CW'(STK_DEPTH));
    assign empty    = (cnt_q == '0);
    assign push_idx = IW'(cnt_q);
    assign top_idx  = IW'(cnt_q - 1'b1);

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (PC_ret) begin
            if (!empty) begin
                pc_d  = stk_mem[top_idx];
                cnt_d = cnt_q - 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (PC_call) begin
            // A call on a full stack is dropped entirely, including the jump.
            if (!full) begin
                push_en = 1'b1;
                pc_d    = PC_addr;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (PC_ld) begin
            pc_d = PC_addr;
        end else if (PC_rel) begin
            pc_d = pc_q + PC_off;
        end else if (PC_up) begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge Clk) begin
        if (PC_clr) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_en && !PC_clr) begin
            stk_mem[push_idx] <= seq_pc;
        end
    end

    assign stk_cnt   = cnt_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;
`else
    logic unused_ret;
    assign unused_ret = PC_ret;

    // Without a stack, call degrades to a plain jump and ret never acts.
    always_comb begin
        pc_d = pc_q;
        if (PC_call || PC_ld) begin
            pc_d = PC_addr;
        end else if (PC_rel) begin
            pc_d = pc_q + PC_off;
        end else if (PC_up) begin
            pc_d = seq_pc;
        end
    end

    assign stk_cnt   = '0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: vector table plus directed call/return sequences.
module tb_pc_seq;

    logic       Clk = 1'b0;
    logic       PC_clr = 1'b0, PC_up = 1'b0, PC_ld = 1'b0, PC_rel = 1'b0;
    logic       PC_call = 1'b0, PC_ret = 1'b0;
    logic [6:0] PC_addr = '0, PC_off = '0;
    logic [6:0] PCout;
    logic [2:0] stk_cnt;
    logic       stk_full, stk_empty, stk_err;

    logic       c99_clr = 1'b0, c99_up = 1'b0, c99_ld = 1'b0;
    logic [6:0] c99_addr = '0;
    logic [6:0] pc99;
    logic [2:0] cnt99;
    logic       full99, empty99, err99;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pc_seq #(.AW(7), .PC_MAX(127), .STK_DEPTH(4)) dut (
        .Clk(Clk), .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_rel(PC_rel),
        .PC_call(PC_call), .PC_ret(PC_ret), .PC_addr(PC_addr), .PC_off(PC_off),
        .PCout(PCout), .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty),
        .stk_err(stk_err)
    );

    pc_seq #(.AW(7), .PC_MAX(99), .STK_DEPTH(4)) dut99 (
        .Clk(Clk), .PC_clr(c99_clr), .PC_up(c99_up), .PC_ld(c99_ld), .PC_rel(1'b0),
        .PC_call(1'b0), .PC_ret(1'b0), .PC_addr(c99_addr), .PC_off(7'd0),
        .PCout(pc99), .stk_cnt(cnt99), .stk_full(full99), .stk_empty(empty99),
        .stk_err(err99)
    );

    typedef struct {
        logic       clr, up, ld, rel, call, ret;
        logic [6:0] addr, off, exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk(string nm, int exp_pc, int exp_cnt, int exp_err);
        $display("txn %-12s pc=%0d cnt=%0d full=%0b empty=%0b err=%0b",
                 nm, PCout, stk_cnt, stk_full, stk_empty, stk_err);
        cmp({nm, ".pc"}, int'(PCout), exp_pc);
        cmp({nm, ".cnt"}, int'(stk_cnt), exp_cnt);
        cmp({nm, ".err"}, int'(stk_err), exp_err);
        cmp({nm, ".empty"}, int'(stk_empty), (exp_cnt == 0) ? 1 : 0);
        cmp({nm, ".full"}, int'(stk_full), (exp_cnt == 4) ? 1 : 0);
    endtask

    task automatic cmd(logic clr, logic up, logic ld, logic rel, logic call, logic ret,
                       logic [6:0] addr, logic [6:0] off);
        PC_clr = clr; PC_up = up; PC_ld = ld; PC_rel = rel;
        PC_call = call; PC_ret = ret; PC_addr = addr; PC_off = off;
        @(posedge Clk);
        #1;
        PC_clr = 0; PC_up = 0; PC_ld = 0; PC_rel = 0; PC_call = 0; PC_ret = 0;
    endtask

    task automatic cmd99(logic clr, logic up, logic ld, logic [6:0] addr, int exp_pc, string nm);
        c99_clr = clr; c99_up = up; c99_ld = ld; c99_addr = addr;
        @(posedge Clk);
        #1;
        c99_clr = 0; c99_up = 0; c99_ld = 0;
        $display("txn %-12s pc99=%0d", nm, pc99);
        cmp(nm, int'(pc99), exp_pc);
    endtask

    initial begin
        int exp_pc;

        // {clr, up, ld, rel, call, ret, addr, off, expected PC}
        vecs.push_back('{0, 0, 1, 0, 0, 0, 7'd100, 7'd0,   7'd100});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 7'd0,   7'd5,   7'd105});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 7'd0,   7'h7B,  7'd100});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 7'd0,   7'd0,   7'd101});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 7'd0,   7'd0,   7'd101});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 7'd127, 7'd0,   7'd127});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 7'd0,   7'd0,   7'd0});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 7'd2,   7'd0,   7'd2});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 7'd0,   7'h7E,  7'd0});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 7'd20,  7'd9,   7'd20});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 7'd0,   7'd3,   7'd23});
        vecs.push_back('{1, 1, 1, 0, 0, 0, 7'd50,  7'd0,   7'd0});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 7'd126, 7'd0,   7'd126});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 7'd0,   7'd0,   7'd127});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 7'd0,   7'd0,   7'd0});

        @(posedge Clk);
        #1;
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset", 0, 0, 0);

        foreach (vecs[i]) begin
            cmd(vecs[i].clr, vecs[i].up, vecs[i].ld, vecs[i].rel, vecs[i].call,
                vecs[i].ret, vecs[i].addr, vecs[i].off);
            chk($sformatf("vec%0d", i), int'(vecs[i].exp_pc), 0, 0);
        end

        // Increment wrap at PC_MAX=127 over 130 cycles, then hold.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        exp_pc = 0;
        for (int i = 0; i < 130; i++) begin
            cmd(0, 1, 0, 0, 0, 0, 0, 0);
            exp_pc = (exp_pc >= 127) ? 0 : exp_pc + 1;
            cmp($sformatf("up%0d", i), int'(PCout), exp_pc);
        end
        $display("txn up-run end pc=%0d", PCout);
        for (int i = 0; i < 3; i++) begin
            cmd(0, 0, 0, 0, 0, 0, 0, 0);
            chk("hold", 2, 0, 0);
        end

        // Loaded value above PC_MAX wraps on the next increment.
        cmd99(1, 0, 0, 0,   0,   "m99.clr");
        cmd99(0, 0, 1, 120, 120, "m99.ld120");
        cmd99(0, 1, 0, 0,   0,   "m99.up");
        cmd99(0, 0, 1, 98,  98,  "m99.ld98");
        cmd99(0, 1, 0, 0,   99,  "m99.up99");
        cmd99(0, 1, 0, 0,   0,   "m99.wrap");

`ifdef PC_STACK_EN
        // Nested call/return.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        cmd(0, 0, 1, 0, 0, 0, 10, 0);
        cmd(0, 0, 0, 0, 1, 0, 50, 0);  chk("call50", 50, 1, 0);
        cmd(0, 1, 0, 0, 0, 0, 0, 0);   chk("up51", 51, 1, 0);
        cmd(0, 0, 0, 0, 1, 0, 70, 0);  chk("call70", 70, 2, 0);
        cmd(0, 0, 0, 0, 0, 1, 0, 0);   chk("ret52", 52, 1, 0);
        cmd(0, 0, 0, 0, 0, 1, 0, 0);   chk("ret11", 11, 0, 0);

        // Overflow: fifth call is ignored.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 1, 0, 10, 0);  chk("ovf.c1", 10, 1, 0);
        cmd(0, 0, 0, 0, 1, 0, 20, 0);  chk("ovf.c2", 20, 2, 0);
        cmd(0, 0, 0, 0, 1, 0, 30, 0);  chk("ovf.c3", 30, 3, 0);
        cmd(0, 0, 0, 0, 1, 0, 40, 0);  chk("ovf.c4", 40, 4, 0);
        cmd(0, 0, 0, 0, 1, 0, 99, 0);  chk("ovf.c5", 40, 4, 1);
        cmd(0, 0, 0, 0, 0, 1, 0, 0);   chk("ovf.ret", 31, 3, 1);

        // Underflow after clear.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);   chk("unf.clr", 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 1, 0, 0);   chk("unf.ret", 0, 0, 1);
        cmd(0, 1, 0, 0, 0, 0, 0, 0);   chk("unf.sticky", 1, 0, 1);

        // Priority: ret beats call and up; clr beats ld.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        cmd(0, 0, 1, 0, 0, 0, 5, 0);
        cmd(0, 0, 0, 0, 1, 0, 60, 0);  chk("pri.call", 60, 1, 0);
        cmd(0, 1, 0, 0, 1, 1, 80, 0);  chk("pri.ret", 6, 0, 0);
        cmd(1, 0, 1, 0, 0, 0, 77, 0);  chk("pri.clr", 0, 0, 0);
`else
        // Stack compiled out: call is a jump, ret is transparent.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 1, 0, 40, 0);  chk("ns.call40", 40, 0, 0);
        cmd(0, 1, 0, 0, 0, 1, 0, 0);   chk("ns.retup", 41, 0, 0);
        cmd(0, 0, 0, 0, 0, 1, 0, 0);   chk("ns.ret", 41, 0, 0);
        cmd(0, 0, 1, 0, 1, 0, 33, 0);  chk("ns.callld", 33, 0, 0);
        cmd(0, 0, 0, 1, 0, 1, 0, 4);   chk("ns.retrel", 37, 0, 0);
        cmd(1, 0, 1, 0, 0, 0, 77, 0);  chk("ns.clr", 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
